// File: rtl/ecc_130_enc_wr_stage_if.sv
// Valid/ready bundle between the FIFO write requester, the encoder stage and the storage array.
// The slave side is the encoder stage; the master side drives beats in and drains them.
interface ecc_130_enc_wr_stage_if #(
    parameter int DATA_WIDTH   = 130,
    parameter int PARITY_WIDTH = 9
);
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_WIDTH-1:0]   in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_WIDTH-1:0]   out_data;
    logic [PARITY_WIDTH-1:0] out_parity;
    logic                    out_fault;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_parity, out_fault
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_parity, out_fault
    );
endinterface

// File: rtl/ecc_130_enc_wr_stage.sv
// Registered write-side SECDED encoder for 130-bit FIFO words with lockstep-checked parity
// generation, sticky fault status and one-shot single/double-bit error injection.
module ecc_130_enc_wr_stage #(
    parameter int DATA_WIDTH   = 130,
    parameter int PARITY_WIDTH = 9
) (
    input  logic                         clk,
    input  logic                         rst,
    ecc_130_enc_wr_stage_if.slave        bus,
    input  logic                         bypass,
    input  logic                         ecc_fault_detc_en,
    input  logic                         lock_tst,
    input  logic                         inj_sbit_req,
    input  logic                         inj_dbit_req,
    output logic                         inj_armed,
    output logic                         ecc_fault,
    output logic                         fault_sticky,
    output logic [7:0]                   fault_cnt,
    input  logic                         fault_clr
);

    localparam int CW_LEN = DATA_WIDTH + PARITY_WIDTH - 1;

    typedef enum logic [1:0] {
        INJ_IDLE,
        INJ_SBIT,
        INJ_DBIT
    } inj_state_e;

    // Hamming positions 1..CW_LEN; data bits occupy the non-power-of-two slots in order.
    function automatic logic [PARITY_WIDTH-1:0] encode(input logic [DATA_WIDTH-1:0] d);
        logic [PARITY_WIDTH-1:0] p;
        logic [7:0]              di;
        logic [7:0]              pos_b;
        p  = '0;
        di = 8'd0;
        for (int pos = 1; pos <= CW_LEN; pos++) begin
            pos_b = 8'(pos);
            if ((pos_b & (pos_b - 8'd1)) != 8'd0) begin
                if (d[di]) p[7:0] = p[7:0] ^ pos_b;
                di = di + 8'd1;
            end
        end
        p[PARITY_WIDTH-1] = ^{d, p[7:0]};
        return p;
    endfunction

    inj_state_e              inj_state_q, inj_state_d;
    logic                    inj_armed_q;
    logic                    out_valid_q;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic [PARITY_WIDTH-1:0] out_parity_q, out_parity_d;
    logic                    out_fault_q;
    logic                    ecc_fault_q;
    logic                    fault_sticky_q, fault_sticky_d;
    logic [7:0]              fault_cnt_q, fault_cnt_d;

    logic                    accept;
    logic                    beat_fault;
    logic                    fault_acc;
    logic [1:0]              inj_mask;
    logic [PARITY_WIDTH-1:0] par_c0, par_c1, par_c1_chk;

    assign bus.in_ready = ~out_valid_q | bus.out_ready;
    assign accept       = bus.in_valid & bus.in_ready;

    // Both copies must survive synthesis as separate logic for the compare to mean anything.
    assign par_c0     = encode(bus.in_data);
    assign par_c1     = encode(bus.in_data);
    assign par_c1_chk = par_c1 ^ {{(PARITY_WIDTH-1){1'b0}}, lock_tst};
    assign beat_fault = ecc_fault_detc_en & ~bypass & (par_c0 != par_c1_chk);
    assign fault_acc  = accept & beat_fault;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        inj_state_d = accept ? INJ_IDLE : inj_state_q;
        if (inj_dbit_req) begin
            inj_state_d = INJ_DBIT;
        end else if (inj_sbit_req && (inj_state_d != INJ_DBIT)) begin
            inj_state_d = INJ_SBIT;
        end

        unique case (inj_state_q)
            INJ_SBIT: inj_mask = 2'b01;
            INJ_DBIT: inj_mask = 2'b11;
            default:  inj_mask = 2'b00;
        endcase

        out_data_d   = bus.in_data ^ {{(DATA_WIDTH-2){1'b0}}, inj_mask};
        out_parity_d = bypass ? '0 : par_c0;

        fault_sticky_d = fault_sticky_q;
        fault_cnt_d    = fault_cnt_q;
        if (fault_clr) begin
            fault_sticky_d = fault_acc;
            fault_cnt_d    = fault_acc ? 8'd1 : 8'd0;
        end else if (fault_acc) begin
            fault_sticky_d = 1'b1;
            if (fault_cnt_q != 8'hFF) fault_cnt_d = fault_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            // NOTE: the datapath register is reset as well because out_data/out_parity must read 0.
            inj_state_q    <= INJ_IDLE;
            inj_armed_q    <= 1'b0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_parity_q   <= '0;
            out_fault_q    <= 1'b0;
            ecc_fault_q    <= 1'b0;
            fault_sticky_q <= 1'b0;
            fault_cnt_q    <= 8'd0;
        end else begin
            inj_state_q    <= inj_state_d;
            inj_armed_q    <= (inj_state_d != INJ_IDLE);
            ecc_fault_q    <= fault_acc;
            fault_sticky_q <= fault_sticky_d;
            fault_cnt_q    <= fault_cnt_d;
            if (accept) begin
                out_valid_q  <= 1'b1;
                out_data_q   <= out_data_d;
                out_parity_q <= out_parity_d;
                out_fault_q  <= beat_fault;
            end else if (bus.out_ready) begin
                out_valid_q  <= 1'b0;
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_parity = out_parity_q;
    assign bus.out_fault  = out_fault_q;
    assign inj_armed      = inj_armed_q;
    assign ecc_fault      = ecc_fault_q;
    assign fault_sticky   = fault_sticky_q;
    assign fault_cnt      = fault_cnt_q;

endmodule

// File: tb/tb_ecc_130_enc_wr_stage.sv
// Scoreboard bench for ecc_130_enc_wr_stage: a driver pushes expected beats on accept and a
// monitor pops and compares whenever the stage presents a beat.
module tb_ecc_130_enc_wr_stage;

    typedef struct {
        logic [129:0] data;
        logic [8:0]   par;
        logic         fault;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       bypass, ecc_fault_detc_en, lock_tst;
    logic       inj_sbit_req, inj_dbit_req, fault_clr;
    logic       inj_armed, ecc_fault, fault_sticky;
    logic [7:0] fault_cnt;

    ecc_130_enc_wr_stage_if bus ();

    ecc_130_enc_wr_stage dut (
        .clk               (clk),
        .rst               (rst),
        .bus               (bus),
        .bypass            (bypass),
        .ecc_fault_detc_en (ecc_fault_detc_en),
        .lock_tst          (lock_tst),
        .inj_sbit_req      (inj_sbit_req),
        .inj_dbit_req      (inj_dbit_req),
        .inj_armed         (inj_armed),
        .ecc_fault         (ecc_fault),
        .fault_sticky      (fault_sticky),
        .fault_cnt         (fault_cnt),
        .fault_clr         (fault_clr)
    );

    always #5 clk = ~clk;

    beat_t        sb[$];
    int           n_vec = 0, n_miss = 0;
    int           n_pulse = 0, n_pop = 0;
    int           inj_m = 0;
    bit           chk_rdy = 1'b0;
    logic [129:0] last_data;
    logic [8:0]   last_par;

    // Reference encoder: data bit i lands at position i+1 shifted past every parity slot.
    function automatic logic [8:0] ref_enc(input logic [129:0] d);
        logic [8:0] p;
        int         pos;
        p = '0;
        for (int i = 0; i < 130; i++) begin
            pos = i + 1;
            for (int k = 0; k < 8; k++) if ((1 << k) <= pos) pos++;
            if (d[i]) p[7:0] = p[7:0] ^ pos[7:0];
        end
        p[8] = (^d) ^ (^p[7:0]);
        return p;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [129:0] d, input logic byp = 1'b0, input logic en = 1'b1,
                        input logic lt = 1'b0, input bit use_exp = 1'b0,
                        input logic [8:0] exp_par = 9'h000);
        beat_t e;
        bit    acc;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bypass = byp; ecc_fault_detc_en = en; lock_tst = lt;
        for (int w = 0; w < 200; w++) begin
            #2;
            acc = bus.in_ready;
            @(posedge clk);
            if (acc) begin
                e.data  = d ^ ((inj_m == 2) ? 130'h3 : (inj_m == 1) ? 130'h1 : 130'h0);
                e.par   = use_exp ? exp_par : (byp ? 9'h000 : ref_enc(d));
                e.fault = en && !byp && lt;
                sb.push_back(e);
                inj_m = 0;
                #1 bus.in_valid = 1'b0;
                check("out_valid_latency", bus.out_valid, 1);
                return;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        n_vec++; n_miss++;
        $display("FAIL accept_timeout: in_ready stayed 0 for 200 cycles, wanted 1");
    endtask

    task automatic arm(input logic s, input logic d);
        @(negedge clk);
        inj_sbit_req = s; inj_dbit_req = d;
        @(posedge clk);
        #1 inj_sbit_req = 1'b0; inj_dbit_req = 1'b0;
        if (d) inj_m = 2;
        else if (s && inj_m != 2) inj_m = 1;
        check("inj_armed_after_req", inj_armed, inj_m != 0);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #4;
            if (sb.size() == 0 && !bus.out_valid) return;
        end
        n_vec++; n_miss++;
        $display("FAIL drain_timeout: %0d beats still expected, wanted 0", sb.size());
    endtask

    // Monitor: compares the presented beat every cycle (so stalls must hold it) and pops on handshake.
    initial begin
        forever begin
            @(negedge clk); #3;
            if (ecc_fault === 1'b1) n_pulse++;
            if (chk_rdy) check("in_ready_stall", bus.in_ready, !(bus.out_valid && !bus.out_ready));
            if (bus.out_valid === 1'b1 && rst === 1'b0) begin
                if (sb.size() == 0) begin
                    n_vec++; n_miss++;
                    $display("FAIL unexpected_beat: got data %0h, expected no beat", bus.out_data);
                end else begin
                    check("out_data",   bus.out_data,   sb[0].data);
                    check("out_parity", bus.out_parity, sb[0].par);
                    check("out_fault",  bus.out_fault,  sb[0].fault);
                    if (bus.out_ready) begin
                        last_data = bus.out_data;
                        last_par  = bus.out_parity;
                        void'(sb.pop_front());
                        n_pop++;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [129:0] v;
        logic [8:0]   synd;
        int           pop0;

        rst = 1'b1; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
        bypass = 1'b0; ecc_fault_detc_en = 1'b1; lock_tst = 1'b0;
        inj_sbit_req = 1'b0; inj_dbit_req = 1'b0; fault_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk); #3;
        check("rst_out_valid",  bus.out_valid,  0);
        check("rst_in_ready",   bus.in_ready,   1);
        check("rst_out_data",   bus.out_data,   0);
        check("rst_out_parity", bus.out_parity, 0);
        check("rst_out_fault",  bus.out_fault,  0);
        check("rst_ecc_fault",  ecc_fault,      0);
        check("rst_sticky",     fault_sticky,   0);
        check("rst_cnt",        fault_cnt,      0);
        check("rst_inj_armed",  inj_armed,      0);

        // Hand-computed parity: bit0 at position 3 -> 9'h103; bit129 at position 138 -> 9'h08A.
        send(130'h0, 1'b0, 1'b1, 1'b0, 1'b1, 9'h000);
        send(130'h1, 1'b0, 1'b1, 1'b0, 1'b1, 9'h103);
        v = '0; v[129] = 1'b1;
        send(v, 1'b0, 1'b1, 1'b0, 1'b1, 9'h08A);
        wait_drain();
        synd = ref_enc(last_data) ^ last_par;
        check("decode_syndrome_bit129", synd, 0);
        send({130{1'b1}});
        send({65{2'b10}});
        send(130'h3_0000_0000_0000_0000_0000_0000_0000_00C5, 1'b1);
        wait_drain();

        // Back-to-back stream with a 3-cycle downstream stall.
        chk_rdy = 1'b1;
        pop0 = n_pop;
        fork
            for (int i = 0; i < 16; i++) send({2'b10, 96'h0, 32'(i) * 32'h0101_0101});
            begin
                repeat (6) @(negedge clk);
                bus.out_ready = 1'b0;
                repeat (3) @(negedge clk);
                bus.out_ready = 1'b1;
            end
        join
        wait_drain();
        chk_rdy = 1'b0;
        check("stream_beats_out", n_pop - pop0, 16);

        // Lockstep fault path.
        n_pulse = 0;
        send(130'h1234, 1'b0, 1'b1, 1'b1);
        send(130'h5678, 1'b0, 1'b1, 1'b1);
        wait_drain();
        check("fault_pulses_2", n_pulse, 2);
        check("fault_cnt_2",    fault_cnt, 2);
        check("fault_sticky_1", fault_sticky, 1);
        send(130'h9ABC, 1'b0, 1'b0, 1'b1);
        send(130'hDEF0, 1'b1, 1'b1, 1'b1);
        wait_drain();
        check("fault_cnt_no_inc", fault_cnt, 2);
        for (int i = 0; i < 300; i++) send(130'(i), 1'b0, 1'b1, 1'b1);
        wait_drain();
        check("fault_cnt_sat",   fault_cnt, 255);
        check("fault_pulses_302", n_pulse, 302);
        @(negedge clk); fault_clr = 1'b1;
        @(posedge clk); #1 fault_clr = 1'b0;
        check("clr_cnt",    fault_cnt, 0);
        check("clr_sticky", fault_sticky, 0);

        // One-shot injection.
        arm(1'b1, 1'b0);
        send(130'h0, 1'b0, 1'b1, 1'b0, 1'b1, 9'h000);
        check("inj_disarm_sbit", inj_armed, 0);
        arm(1'b1, 1'b1);
        send(130'hF0);
        arm(1'b1, 1'b0);
        arm(1'b0, 1'b1);
        send(130'hAA55);
        arm(1'b1, 1'b0);
        send(130'hFF00, 1'b1);
        wait_drain();

        // Reset with a stalled beat held and DBIT armed.
        bus.out_ready = 1'b0;
        send(130'h777);
        arm(1'b0, 1'b1);
        @(negedge clk); #3;
        check("stall_in_ready_0", bus.in_ready, 0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        sb.delete();
        inj_m = 0;
        @(negedge clk); #3;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_inj_armed", inj_armed, 0);
        check("midrst_in_ready",  bus.in_ready, 1);
        bus.out_ready = 1'b1;
        send(130'h3C);
        wait_drain();
        check("scoreboard_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
